// File: rtl/online_mult_seq_ctrl_pkg.sv
// Signed-digit encoding shared by the online multiplier sequencer and its
// sub-blocks. An illegal code is folded to zero so that it cannot reach the core.
package online_mult_seq_ctrl_pkg;

    typedef logic [1:0] sd_t;

    localparam sd_t SD_POS  = 2'b10;
    localparam sd_t SD_NEG  = 2'b01;
    localparam sd_t SD_ZERO = 2'b00;

    function automatic logic sd_legal(input sd_t d);
        return d != 2'b11;
    endfunction

    function automatic sd_t sd_clean(input sd_t d);
        return sd_legal(d) ? d : SD_ZERO;
    endfunction

endpackage

// File: rtl/online_mult_seq_ctrl_if.sv
// Operand and product handshake bundle. The master side is the operand source
// and product consumer. The slave side is the sequencer.
interface online_mult_seq_ctrl_if
    import online_mult_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic              in_valid;
    logic              in_ready;
    sd_t [WIDTH-1:0]   x_in;
    sd_t [WIDTH-1:0]   y_in;
    logic              out_valid;
    logic              out_ready;
    sd_t [WIDTH-1:0]   z_out;

    modport master (
        output in_valid, x_in, y_in, out_ready,
        input  in_ready, out_valid, z_out
    );

    modport slave (
        input  in_valid, x_in, y_in, out_ready,
        output in_ready, out_valid, z_out
    );
endinterface

// File: rtl/online_mult_seq_ctrl_sd_issue_pipe.sv
// Delay line that tracks each issued iteration (valid and index) until the
// core returns the matching result digit. A depth of zero gives a pass-through.
module sd_issue_pipe #(
    parameter int DEPTH = 1,
    parameter int IW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [IW-1:0] in_idx,
    output logic          out_valid,
    output logic [IW-1:0] out_idx
);
    localparam int SLOTS = (DEPTH > 0) ? DEPTH : 1;

    logic [SLOTS-1:0]         valid_q, valid_d;
    logic [SLOTS-1:0][IW-1:0] idx_q, idx_d;

    always_comb begin
        valid_d[0] = in_valid;
        idx_d[0]   = in_idx;
        for (int i = 1; i < SLOTS; i++) begin
            valid_d[i] = valid_q[i-1];
            idx_d[i]   = idx_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            idx_q   <= '0;
        end else begin
            valid_q <= valid_d;
            idx_q   <= idx_d;
        end
    end

    assign out_valid = (DEPTH == 0) ? in_valid : valid_q[SLOTS-1];
    assign out_idx   = (DEPTH == 0) ? in_idx   : idx_q[SLOTS-1];
endmodule

// File: rtl/online_mult_seq_ctrl.sv
// Sequencer for a digit-serial radix-2 online multiplier. It streams one operand
// pair MSD-first into the core and gathers the non-delayed result digits into z_out.
module online_mult_seq_ctrl
    import online_mult_seq_ctrl_pkg::*;
#(
    parameter  int WIDTH        = 32,
    parameter  int ONLINE_DELAY = 3,
    parameter  int CORE_LAT     = 1,
    localparam int STAGES       = WIDTH + ONLINE_DELAY,
    localparam int JW           = $clog2(STAGES)
) (
    input  logic                  clk,
    input  logic                  rst,
    online_mult_seq_ctrl_if.slave io,
    output logic                  core_start,
    output logic                  core_en,
    output logic [JW-1:0]         core_j,
    output sd_t                   core_x,
    output sd_t                   core_y,
    input  sd_t                   core_z,
    output logic                  busy,
    output logic                  digit_err
);
    localparam int            XW     = $clog2(WIDTH);
    localparam logic [JW-1:0] J_W    = JW'(WIDTH);
    localparam logic [JW-1:0] J_D    = JW'(ONLINE_DELAY);
    localparam logic [JW-1:0] J_LAST = JW'(STAGES - 1);
    localparam logic [2:0]    D_LAST = 3'((CORE_LAT > 0) ? CORE_LAT - 1 : 0);

    typedef enum logic [2:0] {IDLE, INIT, RUN, DRAIN, DONE} state_e;

    state_e          state_q, state_d;
    sd_t [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic [JW-1:0]   j_q, j_d;
    logic [2:0]      drain_q, drain_d;
    logic            err_q, err_d;
    logic            accept;
    logic            cap_valid;
    logic [JW-1:0]   cap_j, cap_k;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (io.in_valid) state_d = INIT;
            INIT:    state_d = RUN;
            RUN:     if (j_q == J_LAST) state_d = (CORE_LAT > 0) ? DRAIN : DONE;
            DRAIN:   if (drain_q == D_LAST) state_d = DONE;
            DONE:    if (io.out_ready) state_d = io.in_valid ? INIT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // In DONE the consumer taking the product frees the operand slot in the same cycle.
    always_comb begin
        io.in_ready  = 1'b0;
        io.out_valid = 1'b0;
        core_start   = 1'b0;
        core_en      = 1'b0;
        case (state_q)
            IDLE:    io.in_ready = 1'b1;
            INIT:    core_start = 1'b1;
            RUN:     core_en = 1'b1;
            DONE: begin
                io.out_valid = 1'b1;
                io.in_ready  = io.out_ready;
            end
            default: ;
        endcase
    end

    assign accept    = io.in_valid && io.in_ready;
    assign busy      = (state_q != IDLE);
    assign core_j    = j_q;
    assign core_x    = (core_en && j_q < J_W) ? x_q[j_q[XW-1:0]] : SD_ZERO;
    assign core_y    = (core_en && j_q < J_W) ? y_q[j_q[XW-1:0]] : SD_ZERO;
    assign io.z_out  = z_q;
    assign digit_err = err_q;

    sd_issue_pipe #(
        .DEPTH (CORE_LAT),
        .IW    (JW)
    ) u_issue_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (core_en),
        .in_idx    (j_q),
        .out_valid (cap_valid),
        .out_idx   (cap_j)
    );

    assign cap_k = cap_j - J_D;

    // Result digits from the first ONLINE_DELAY iterations are only warm-up and are dropped.
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        j_d     = j_q;
        drain_d = drain_q;
        err_d   = err_q;
        if (accept) begin
            for (int i = 0; i < WIDTH; i++) begin
                x_d[i] = sd_clean(io.x_in[i]);
                y_d[i] = sd_clean(io.y_in[i]);
                if (!sd_legal(io.x_in[i]) || !sd_legal(io.y_in[i])) err_d = 1'b1;
            end
        end
        if (state_q == RUN)   j_d     = (j_q == J_LAST) ? '0 : j_q + 1'b1;
        if (state_q == DRAIN) drain_d = (drain_q == D_LAST) ? '0 : drain_q + 1'b1;
        if (cap_valid && cap_j >= J_D) begin
            z_d[cap_k[XW-1:0]] = sd_clean(core_z);
            if (!sd_legal(core_z)) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            j_q     <= '0;
            drain_q <= '0;
            err_q   <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            j_q     <= j_d;
            drain_q <= drain_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_online_mult_seq_ctrl.sv
// Bench for the online multiplier sequencer with a behavioural serial core.
// It runs three lanes with core latencies 1 (the default), 0 and 3.
module tb_online_mult_seq_ctrl;
    import online_mult_seq_ctrl_pkg::*;

    localparam int W      = 32;
    localparam int D      = 3;
    localparam int STAGES = W + D;
    localparam int JW     = $clog2(STAGES);

    typedef sd_t [W-1:0] vec_t;

    logic          clk;
    logic          rst;
    logic          in_valid   [3];
    vec_t          x_in       [3];
    vec_t          y_in       [3];
    logic          out_ready  [3];
    logic          in_ready   [3];
    logic          out_valid  [3];
    logic          core_start [3];
    logic          core_en    [3];
    logic          busy       [3];
    logic          digit_err  [3];
    logic [JW-1:0] core_j     [3];
    vec_t          z_out      [3];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    // A digit's value as an integer scaled by 2^sh.
    function automatic logic signed [127:0] sd_weight(input sd_t d, input int sh);
        logic signed [127:0] one;
        one = 128'sd1 <<< sh;
        if (d == SD_POS) return one;
        if (d == SD_NEG) return -one;
        return '0;
    endfunction

    // Pick output digit k so that the emitted prefix follows the product
    // (values are scaled by 2^64).
    function automatic sd_t select_digit(input logic signed [127:0] p, input logic signed [127:0] z,
                                         input int k);
        logic signed [127:0] diff, thr;
        diff = p - z;
        thr  = 128'sd1 <<< (62 - k);
        if (diff > thr)  return SD_POS;
        if (diff < -thr) return SD_NEG;
        return SD_ZERO;
    endfunction

    // Combinational golden multiplier, computed over the whole operand arrays.
    function automatic vec_t golden(input vec_t xo, input vec_t yo);
        vec_t zo;
        logic signed [127:0] px, py, pz;
        zo = '0;
        px = '0;
        py = '0;
        pz = '0;
        for (int j = 0; j < STAGES; j++) begin
            if (j < W) begin
                px += sd_weight(xo[j], 31 - j);
                py += sd_weight(yo[j], 31 - j);
            end
            if (j >= D) begin
                zo[j-D] = select_digit(px * py, pz, j - D);
                pz += sd_weight(zo[j-D], 63 - (j - D));
            end
        end
        return zo;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < W; i++) begin
            case ($urandom_range(2))
                0:       v[i] = SD_ZERO;
                1:       v[i] = SD_POS;
                default: v[i] = SD_NEG;
            endcase
        end
        return v;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : lane
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 0 : 3);

        online_mult_seq_ctrl_if #(.WIDTH(W)) bus ();

        sd_t                 cx, cy, cz, z_now;
        logic [JW-1:0]       cj;
        logic signed [127:0] acc_x, acc_y, acc_z, nx, ny;
        sd_t                 zpipe [4];

        assign bus.in_valid  = in_valid[g];
        assign bus.x_in      = x_in[g];
        assign bus.y_in      = y_in[g];
        assign bus.out_ready = out_ready[g];
        assign in_ready[g]   = bus.in_ready;
        assign out_valid[g]  = bus.out_valid;
        assign z_out[g]      = bus.z_out;
        assign core_j[g]     = cj;

        online_mult_seq_ctrl #(
            .WIDTH        (W),
            .ONLINE_DELAY (D),
            .CORE_LAT     (LAT)
        ) dut (
            .clk        (clk),
            .rst        (rst),
            .io         (bus),
            .core_start (core_start[g]),
            .core_en    (core_en[g]),
            .core_j     (cj),
            .core_x     (cx),
            .core_y     (cy),
            .core_z     (cz),
            .busy       (busy[g]),
            .digit_err  (digit_err[g])
        );

        // Serial core: accumulates operand prefixes and emits one digit per issue.
        // Warm-up digits are deliberately nonzero so that an offset capture shows up.
        always_comb begin
            nx    = acc_x;
            ny    = acc_y;
            z_now = {cj[0], ~cj[0]};
            if (cj < JW'(W)) begin
                nx = acc_x + sd_weight(cx, 31 - int'(cj));
                ny = acc_y + sd_weight(cy, 31 - int'(cj));
            end
            if (cj >= JW'(D)) z_now = select_digit(nx * ny, acc_z, int'(cj) - D);
        end

        always_ff @(posedge clk) begin
            if (rst || core_start[g]) begin
                acc_x <= '0;
                acc_y <= '0;
                acc_z <= '0;
            end else if (core_en[g]) begin
                acc_x <= nx;
                acc_y <= ny;
                if (cj >= JW'(D)) acc_z <= acc_z + sd_weight(z_now, 63 - (int'(cj) - D));
            end
            zpipe[0] <= z_now;
            for (int i = 1; i < 4; i++) zpipe[i] <= zpipe[i-1];
        end

        assign cz = (LAT == 0) ? z_now : zpipe[(LAT > 0) ? LAT - 1 : 0];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input int l, input vec_t xo, input vec_t yo, output int t_hs);
        int n;
        n = 0;
        in_valid[l] = 1'b1;
        x_in[l]     = xo;
        y_in[l]     = yo;
        while (!in_ready[l] && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (in_ready[l] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL send_ready lane %0d: in_ready=%0b required 1", l, in_ready[l]);
        end
        t_hs = cyc;
        tick();
        in_valid[l] = 1'b0;
        checks++;
        if (core_start[l] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL start_pulse lane %0d: core_start=%0b required 1", l, core_start[l]);
        end
    endtask

    task automatic wait_done(input int l, input int t_hs, input int lat, input vec_t exp_z);
        int n;
        n = 0;
        while (!out_valid[l] && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (out_valid[l] !== 1'b1 || cyc != t_hs + 2 + STAGES + lat) begin
            errors++;
            $display("[TB] FAIL latency lane %0d: out_valid=%0b after %0d cycles, required 1 after %0d",
                     l, out_valid[l], cyc - t_hs, 2 + STAGES + lat);
        end
        checks++;
        if (z_out[l] !== exp_z) begin
            errors++;
            $display("[TB] FAIL product lane %0d: z_out=%h required %h", l, z_out[l], exp_z);
        end
    endtask

    task automatic accept_out(input int l);
        out_ready[l] = 1'b1;
        tick();
        out_ready[l] = 1'b0;
        checks++;
        if ({out_valid[l], busy[l], in_ready[l]} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL to_idle lane %0d: {out_valid,busy,in_ready}=%b required 001",
                     l, {out_valid[l], busy[l], in_ready[l]});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        for (int l = 0; l < 3; l++) begin
            checks++;
            if ({in_ready[l], out_valid[l], core_start[l], core_en[l], busy[l], digit_err[l]} !== 6'b100000) begin
                errors++;
                $display("[TB] FAIL reset_flags lane %0d: %b required 100000", l,
                         {in_ready[l], out_valid[l], core_start[l], core_en[l], busy[l], digit_err[l]});
            end
            checks++;
            if (core_j[l] !== '0 || z_out[l] !== '0) begin
                errors++;
                $display("[TB] FAIL reset_data lane %0d: core_j=%0d z_out=%h required 0", l, core_j[l], z_out[l]);
            end
        end
    endtask

    task automatic test_directed();
        vec_t xo, yo, ex;
        int   t;
        xo = '0; yo = '0; ex = '0;
        xo[0] = SD_POS; yo[0] = SD_POS; ex[1] = SD_POS;
        send(0, xo, yo, t);
        wait_done(0, t, 1, ex);
        accept_out(0);
        xo = '0; yo = '0; ex = '0;
        xo[0] = SD_POS; yo[0] = SD_NEG; ex[1] = SD_NEG;
        send(0, xo, yo, t);
        wait_done(0, t, 1, ex);
        accept_out(0);
    endtask

    task automatic test_random();
        vec_t xo, yo;
        int   t;
        for (int n = 0; n < 7; n++) begin
            xo = rand_vec();
            yo = rand_vec();
            if (n == 0) begin
                xo = {W{SD_NEG}};
                yo = {W{SD_POS}};
            end
            send(0, xo, yo, t);
            wait_done(0, t, 1, golden(xo, yo));
            accept_out(0);
        end
    endtask

    task automatic test_back_to_back();
        vec_t xa, ya, xb, yb, held;
        int   t;
        xa = rand_vec(); ya = rand_vec(); xb = rand_vec(); yb = rand_vec();
        send(0, xa, ya, t);
        wait_done(0, t, 1, golden(xa, ya));
        held        = z_out[0];
        in_valid[0] = 1'b1;
        x_in[0]     = xb;
        y_in[0]     = yb;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || z_out[0] !== held) begin
                errors++;
                $display("[TB] FAIL hold_done cycle %0d: out_valid=%0b in_ready=%0b z_out=%h required 1 0 %h",
                         i, out_valid[0], in_ready[0], z_out[0], held);
            end
            tick();
        end
        out_ready[0] = 1'b1;
        t = cyc;
        tick();
        out_ready[0] = 1'b0;
        in_valid[0]  = 1'b0;
        checks++;
        if ({core_start[0], busy[0]} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL b2b_start: {core_start,busy}=%b required 11", {core_start[0], busy[0]});
        end
        wait_done(0, t, 1, golden(xb, yb));
        accept_out(0);
    endtask

    task automatic test_reset_mid_run();
        vec_t xo, yo;
        int   t, n;
        xo = rand_vec(); yo = rand_vec();
        send(0, xo, yo, t);
        n = 0;
        while (!(core_en[0] && core_j[0] == JW'(17)) && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (core_en[0] !== 1'b1 || core_j[0] !== JW'(17)) begin
            errors++;
            $display("[TB] FAIL reach_j17: core_en=%0b core_j=%0d required 1 17", core_en[0], core_j[0]);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({busy[0], out_valid[0], core_en[0], in_ready[0]} !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL mid_run_reset: {busy,out_valid,core_en,in_ready}=%b required 0001",
                     {busy[0], out_valid[0], core_en[0], in_ready[0]});
        end
        xo = rand_vec(); yo = rand_vec();
        send(0, xo, yo, t);
        wait_done(0, t, 1, golden(xo, yo));
        accept_out(0);
    endtask

    task automatic test_digit_err();
        vec_t xo, yo;
        int   t;
        xo = rand_vec(); yo = rand_vec();
        xo[5] = 2'b11;
        send(0, xo, yo, t);
        checks++;
        if (digit_err[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL digit_err_set: digit_err=%0b required 1", digit_err[0]);
        end
        wait_done(0, t, 1, golden(xo, yo));
        accept_out(0);
        checks++;
        if (digit_err[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL digit_err_sticky: digit_err=%0b required 1", digit_err[0]);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (digit_err[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL digit_err_clear: digit_err=%0b required 0", digit_err[0]);
        end
    endtask

    task automatic test_lat_sweep();
        vec_t xo, yo;
        int   t, lat;
        for (int l = 1; l < 3; l++) begin
            lat = (l == 1) ? 0 : 3;
            for (int n = 0; n < 3; n++) begin
                xo = rand_vec(); yo = rand_vec();
                send(l, xo, yo, t);
                wait_done(l, t, lat, golden(xo, yo));
                accept_out(l);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int l = 0; l < 3; l++) begin
            in_valid[l]  = 1'b0;
            out_ready[l] = 1'b0;
            x_in[l]      = '0;
            y_in[l]      = '0;
        end
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        test_digit_err();
        test_lat_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
